// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-requester arbiter for a single fixed-latency memory port
// D-side wins ties unless the I-side has been passed over STARVE_LIMIT times in a row.
module mem_port_arbiter #(
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_req,
  input  logic [31:0]     i_addr,
  output logic            i_done,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [31:0]     d_addr,
  input  logic [0:3][7:0] d_wdata,
  output logic            d_done,
  output logic [0:3][7:0] rdata,
  output logic [31:0]     mem_addr,
  output logic [0:3][7:0] mem_data_in,
  input  logic [0:3][7:0] mem_data_out,
  output logic            mem_write_en,
  output logic            busy,
  output logic            owner
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);
  localparam int         SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_LIMIT);
  localparam bit         STARVE_EN = (STARVE_LIMIT != 0);

  state_t          state, state_next;
  logic [3:0]      cnt;
  logic [SW-1:0]   streak;
  logic            owner_q;
  logic            we_q;
  logic [31:0]     addr_q;
  logic [0:3][7:0] wdata_q;
  logic            grant;
  logic            grant_d;
  logic            force_i;

  assign force_i = STARVE_EN && i_req && (streak == STREAK_MAX);

  always_comb begin
    state_next = state;
    grant      = 1'b0;
    grant_d    = 1'b0;
    case (state)
      IDLE: begin
        if (i_req || d_req) begin
          grant      = 1'b1;
          grant_d    = d_req && !force_i;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (cnt == 4'd0) state_next = RESP;
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      streak  <= '0;
      rdata   <= '0;
      owner_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= '0;
    end else begin
      state <= state_next;
      if (grant) begin
        owner_q <= grant_d;
        addr_q  <= grant_d ? d_addr : i_addr;
        we_q    <= grant_d && d_we;
        wdata_q <= grant_d ? d_wdata : '0;
        cnt     <= CNT_INIT;
        // Streak only grows while the I-side is actually being passed over.
        if (!grant_d || !i_req)
          streak <= '0;
        else if (streak != STREAK_MAX)
          streak <= streak + 1'b1;
      end
      if (state == BUSY) begin
        if (cnt != 4'd0)
          cnt <= cnt - 4'd1;
        else
          rdata <= mem_data_out;
      end
    end
  end

  // The write strobe is tied to the first BUSY cycle, so reset removes it on the same edge.
  assign busy         = (state != IDLE);
  assign owner        = busy && owner_q;
  assign mem_addr     = (state == BUSY) ? addr_q : 32'd0;
  assign mem_data_in  = (state == BUSY) ? wdata_q : '0;
  assign mem_write_en = (state == BUSY) && we_q && (cnt == CNT_INIT);
  assign i_done       = (state == RESP) && !owner_q;
  assign d_done       = (state == RESP) && owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized scoreboard bench for mem_port_arbiter
// A transaction-level model predicts grants; a negedge monitor checks port, done and rdata.
module tb_mem_port_arbiter;

  localparam int LAT  = 3;
  localparam int SLIM = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic            i_req, d_req, d_we;
  logic [31:0]     i_addr, d_addr;
  logic [0:3][7:0] d_wdata, mem_data_out;
  logic            i_done, d_done, mem_write_en, busy, owner;
  logic [0:3][7:0] rdata, mem_data_in;
  logic [31:0]     mem_addr;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MEM_LATENCY(LAT), .STARVE_LIMIT(SLIM)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_done(i_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_done(d_done),
    .rdata(rdata), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out), .mem_write_en(mem_write_en),
    .busy(busy), .owner(owner)
  );

  typedef struct {
    int          g;
    bit          own;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  txn_t        q[$];
  logic [31:0] hist [int];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  bit          mon_en = 1'b0;
  int          next_free = 0;
  int          streak = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // Model: the port is free LAT+2 cycles after each grant; ties follow the streak rule.
  task automatic model_grant();
    txn_t t;
    bit   gd;
    hist[cyc] = mem_data_out;
    if (reset) begin
      q.delete();
      streak    = 0;
      next_free = cyc + 1;
    end else if (cyc >= next_free && (i_req || d_req)) begin
      gd      = d_req && !(i_req && SLIM != 0 && streak == SLIM);
      t.g     = cyc;
      t.own   = gd;
      t.we    = gd && d_we;
      t.addr  = gd ? d_addr : i_addr;
      t.wdata = d_wdata;
      q.push_back(t);
      if (gd && i_req) streak = (streak + 1 > SLIM) ? SLIM : streak + 1;
      else             streak = 0;
      next_free = cyc + LAT + 2;
    end
  endtask

  task automatic random_cycle();
    if (!i_req)                                    i_req = ($urandom_range(2) == 0);
    else if (i_done && $urandom_range(1) == 0)     i_req = 1'b0;
    if (!d_req)                                    d_req = ($urandom_range(2) == 0);
    else if (d_done && $urandom_range(1) == 0)     d_req = 1'b0;
    i_addr       = $urandom;
    d_addr       = $urandom;
    d_we         = 1'($urandom_range(1));
    d_wdata      = $urandom;
    mem_data_out = $urandom;
    model_grant();
  endtask

  task automatic drain();
    i_req = 1'b0;
    d_req = 1'b0;
    for (int k = 0; k < 30 && (q.size() > 0 || cyc < next_free); k++) begin
      @(negedge clk); #1;
      mem_data_out = $urandom;
      model_grant();
    end
    chk("drain_empty", 32'(q.size()), 32'd0);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      txn_t t;
      bit   act_w, rsp;
      t     = '{0, 1'b0, 1'b0, 32'd0, 32'd0};
      act_w = 1'b0;
      rsp   = 1'b0;
      if (q.size() > 0) begin
        t     = q[0];
        act_w = (cyc > t.g) && (cyc <= t.g + LAT);
        rsp   = (cyc == t.g + LAT + 1);
      end
      chk("i_done", 32'(i_done), 32'(rsp && !t.own));
      chk("d_done", 32'(d_done), 32'(rsp && t.own));
      chk("busy", 32'(busy), 32'(act_w || rsp));
      chk("owner", 32'(owner), 32'((act_w || rsp) && t.own));
      chk("mem_addr", mem_addr, act_w ? t.addr : 32'd0);
      if (!act_w || t.we)
        chk("mem_data_in", mem_data_in, act_w ? t.wdata : 32'd0);
      chk("mem_write_en", 32'(mem_write_en), 32'(act_w && t.we && cyc == t.g + 1));
      if (rsp) begin
        chk("rdata", rdata, hist[t.g + LAT]);
        void'(q.pop_front());
      end
    end
  end

  initial begin
    reset        = 1'b1;
    i_req        = 1'b0;
    d_req        = 1'b0;
    d_we         = 1'b0;
    i_addr       = 32'd0;
    d_addr       = 32'd0;
    d_wdata      = '0;
    mem_data_out = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("reset_rdata", rdata, 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_owner", 32'(owner), 32'd0);
    chk("reset_done", 32'({i_done, d_done}), 32'd0);
    chk("reset_wen", 32'(mem_write_en), 32'd0);
    chk("reset_addr", mem_addr, 32'd0);
    reset     = 1'b0;
    mon_en    = 1'b1;
    next_free = cyc;
    model_grant();

    for (int n = 0; n < 800; n++) begin
      @(negedge clk); #1;
      random_cycle();
    end

    // Reset one cycle into a D write: strobe must vanish and no done may follow.
    drain();
    @(negedge clk); #1;
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 32'h0000_0100;
    d_wdata = 32'h0102_0304;
    model_grant();
    @(negedge clk); #1;
    reset = 1'b1;
    d_req = 1'b0;
    model_grant();
    @(negedge clk); #1;
    chk("rdata_after_reset", rdata, 32'd0);
    reset = 1'b0;
    i_req  = 1'b1;
    i_addr = 32'h0000_0040;
    model_grant();

    for (int n = 0; n < 300; n++) begin
      @(negedge clk); #1;
      random_cycle();
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single word-wide memory port between two requesters: instruction fetch (I-side) and data cache refill/write-back (D-side).
- Owns the memory port's address, write-enable and write-data lines, and sequences the port's fixed read latency.
- Returns read data and a one-cycle completion pulse to the requester that owned the transaction.
- D-side has priority, with a starvation guard that guarantees the I-side forward progress.

Parameters:
- MEM_LATENCY, 1: cycles the memory needs from a stable address to valid mem_data_out. Legal range 1..15.
- STARVE_LIMIT, 4: maximum consecutive D grants while i_req is pending before the I-side is forced. 0 means strict D priority.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- i_req  in  1  I-side request; held high until i_done.
- i_addr  in  32  I-side word address.
- i_done  out  1  one-cycle pulse; rdata valid for the I-side.
- d_req  in  1  D-side request; held high until d_done.
- d_we  in  1  D-side write (1) or read (0).
- d_addr  in  32  D-side address.
- d_wdata  in  8x4  D-side write bytes [0:3]; byte 0 = bits 31:24.
- d_done  out  1  one-cycle pulse; write complete, or rdata valid for the D-side.
- rdata  out  8x4  captured read bytes [0:3].
- mem_addr  out  32  memory address.
- mem_data_in  out  8x4  memory write bytes.
- mem_data_out  in  8x4  memory read bytes.
- mem_write_en  out  1  memory write strobe.
- busy  out  1  high in BUSY and RESP.
- owner  out  1  0 = I-side, 1 = D-side; valid while busy.

Behaviour:
- States and transitions:
  - IDLE → BUSY on any request.
  - BUSY → RESP when cnt reaches 0.
  - RESP → IDLE unconditionally.
- Arbitration happens only in IDLE, at cycle T:
  - Only one request pending: grant it.
  - Both pending, STARVE_LIMIT≠0 and streak==STARVE_LIMIT: grant I.
  - Both pending otherwise: grant D.
- Streak counter:
  - Increments on a D grant when i_req is also high.
  - Clears on any I grant.
  - Clears on a D grant made with i_req low.
  - Saturates at STARVE_LIMIT.
- Capture at grant (cycle T): owner, addr, we and wdata are latched. Later changes to requester inputs are ignored until done.
- BUSY, cycles T+1 .. T+MEM_LATENCY:
  - mem_addr = latched address, stable throughout.
  - mem_data_in = latched wdata.
  - cnt loads MEM_LATENCY-1 at grant and decrements each BUSY cycle.
- mem_write_en: high only in cycle T+1, and only for a D write. I-side transactions never write.
- Read capture: in the last BUSY cycle (cnt==0), mem_data_out is registered into rdata on the clock edge. Captured for writes too, but ignored by the requester.
- RESP, cycle T+MEM_LATENCY+1:
  - Exactly one of i_done/d_done pulses, matching owner.
  - rdata holds its value until the next read capture.
- Next grant: earliest at T+MEM_LATENCY+2. A requester still asserting req in that cycle has made a new request. Minimum request-to-done latency is MEM_LATENCY+1 cycles; back-to-back throughput is one transaction per MEM_LATENCY+2 cycles.
- IDLE outputs: mem_addr=0, mem_data_in=0, mem_write_en=0, busy=0, owner=0.
- Address bits: addr[1:0] pass through unmodified; alignment is the requester's responsibility.
- Requests arriving in BUSY or RESP wait; nothing is dropped, since req is level-held.
- Reset values: state=IDLE, cnt=0, streak=0, rdata=0, i_done=0, d_done=0, mem_write_en=0, busy=0, owner=0.
- Reset mid-transaction: the transaction is abandoned, no done pulse is issued, and mem_write_en drops in the same edge. Requesters re-issue after reset.
- A done pulse is never issued without a prior grant. i_done and d_done are never high together.

Test Plan:
- MEM_LATENCY=1, single I read:
  - Stimulus: i_req at T, i_addr=0x40, mem_data_out={0xDE,0xAD,0xBE,0xEF} at T+1.
  - Required: mem_addr=0x40 at T+1, i_done at T+2, rdata=0xDEADBEEF, mem_write_en never high.
- D write:
  - Stimulus: d_req, d_we=1, d_addr=0x100, d_wdata={1,2,3,4}.
  - Required: mem_write_en high for exactly cycle T+1 with mem_addr=0x100 and mem_data_in={1,2,3,4}, d_done at T+2.
- Simultaneous I and D requests at T:
  - Required: D granted first (owner=1); I granted at T+3; i_done at T+5.
- STARVE_LIMIT=2, d_req and i_req held continuously:
  - Required: grant order D, D, I, D, D, I …; no two done pulses closer than 3 cycles.
- MEM_LATENCY=3, D read:
  - Stimulus: mem_addr held stable T+1..T+3; data changed at T+2 and again at T+3.
  - Required: rdata equals the T+3 value; d_done at T+4.
- Reset asserted at T+1 of a D write:
  - Required: mem_write_en=0 at T+2, busy=0, no d_done; a new i_req after reset completes normally.
